// File: rtl/ahb_mem_arbiter.sv
// ahb_mem_arbiter: two-master AHB-Lite arbiter/mux in front of a single-ported memory slave.
// Define ARB_ROUND_ROBIN_EN for alternating grants under contention; default is fixed M0 priority.
module ahb_mem_arbiter #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  M0_HSEL,
   input  logic [ADDR_WIDTH-1:0] M0_HADDR,
   input  logic [1:0]            M0_HTRANS,
   input  logic                  M0_HWRITE,
   input  logic [2:0]            M0_HSIZE,
   input  logic [31:0]           M0_HWDATA,
   input  logic                  M0_HREADY,
   output logic                  M0_HREADYOUT,
   output logic [31:0]           M0_HRDATA,
   input  logic                  M1_HSEL,
   input  logic [ADDR_WIDTH-1:0] M1_HADDR,
   input  logic [1:0]            M1_HTRANS,
   input  logic                  M1_HWRITE,
   input  logic [2:0]            M1_HSIZE,
   input  logic [31:0]           M1_HWDATA,
   input  logic                  M1_HREADY,
   output logic                  M1_HREADYOUT,
   output logic [31:0]           M1_HRDATA,
   output logic                  S_HSEL,
   output logic [ADDR_WIDTH-1:0] S_HADDR,
   output logic [1:0]            S_HTRANS,
   output logic                  S_HWRITE,
   output logic [2:0]            S_HSIZE,
   output logic [31:0]           S_HWDATA,
   output logic                  S_HREADY,
   input  logic                  S_HREADYOUT,
   input  logic [31:0]           S_HRDATA
);
   logic                  live0, live1, cand0, cand1, issue, go, win;
   logic                  pend0, pend1, dp_valid, dp_owner;
   logic [ADDR_WIDTH-1:0] h_addr0, h_addr1, last_addr, w_addr;
   logic [1:0]            h_trans0, h_trans1, w_trans, w_trans_eff;
   logic                  h_write0, h_write1, last_write, w_write, w_pend;
   logic [2:0]            h_size0, h_size1, last_size, w_size;

   assign live0 = M0_HSEL & M0_HTRANS[1] & M0_HREADY & ~pend0;
   assign live1 = M1_HSEL & M1_HTRANS[1] & M1_HREADY & ~pend1;
   assign cand0 = pend0 | live0;
   assign cand1 = pend1 | live1;
   assign issue = S_HREADYOUT & (cand0 | cand1);

`ifdef ARB_ROUND_ROBIN_EN
   // last_grant resets to M1 so the first contended grant goes to M0
   logic last_grant;
   assign win = cand1 & (~cand0 | ~last_grant);
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn)
         last_grant <= 1'b1;
      else if (issue)
         last_grant <= win;
`else
   assign win = cand1 & ~cand0;
`endif

   assign w_pend  = win ? pend1 : pend0;
   assign w_addr  = win ? (pend1 ? h_addr1  : M1_HADDR)  : (pend0 ? h_addr0  : M0_HADDR);
   assign w_trans = win ? (pend1 ? h_trans1 : M1_HTRANS) : (pend0 ? h_trans0 : M0_HTRANS);
   assign w_write = win ? (pend1 ? h_write1 : M1_HWRITE) : (pend0 ? h_write0 : M0_HWRITE);
   assign w_size  = win ? (pend1 ? h_size1  : M1_HSIZE)  : (pend0 ? h_size0  : M0_HSIZE);
   // a SEQ beat that lost continuity with its own previous slave address phase restarts as NONSEQ
   assign w_trans_eff = (w_trans == 2'b11 && (w_pend || (dp_valid && dp_owner != win))) ? 2'b10 : w_trans;

   assign go       = issue & HRESETn;
   assign S_HSEL   = go;
   assign S_HTRANS = go ? w_trans_eff : 2'b00;
   assign S_HADDR  = go ? w_addr : last_addr;
   assign S_HWRITE = go ? w_write : last_write;
   assign S_HSIZE  = go ? w_size : last_size;
   assign S_HWDATA = dp_owner ? M1_HWDATA : M0_HWDATA;
   assign S_HREADY = S_HREADYOUT;
   assign M0_HRDATA = S_HRDATA;
   assign M1_HRDATA = S_HRDATA;
   assign M0_HREADYOUT = ~pend0 & (~dp_valid | dp_owner | S_HREADYOUT);
   assign M1_HREADYOUT = ~pend1 & (~dp_valid | ~dp_owner | S_HREADYOUT);

   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         pend0      <= 1'b0;
         pend1      <= 1'b0;
         dp_valid   <= 1'b0;
         dp_owner   <= 1'b0;
         last_addr  <= '0;
         last_write <= 1'b0;
         last_size  <= 3'b000;
         h_addr0    <= '0;
         h_trans0   <= 2'b00;
         h_write0   <= 1'b0;
         h_size0    <= 3'b000;
         h_addr1    <= '0;
         h_trans1   <= 2'b00;
         h_write1   <= 1'b0;
         h_size1    <= 3'b000;
      end else begin
         if (issue) begin
            last_addr  <= w_addr;
            last_write <= w_write;
            last_size  <= w_size;
         end
         if (S_HREADYOUT) begin
            dp_valid <= issue;
            dp_owner <= win;
         end
         if (issue && !win)
            pend0 <= 1'b0;
         else if (live0) begin
            pend0    <= 1'b1;
            h_addr0  <= M0_HADDR;
            h_trans0 <= M0_HTRANS;
            h_write0 <= M0_HWRITE;
            h_size0  <= M0_HSIZE;
         end
         if (issue && win)
            pend1 <= 1'b0;
         else if (live1) begin
            pend1    <= 1'b1;
            h_addr1  <= M1_HADDR;
            h_trans1 <= M1_HTRANS;
            h_write1 <= M1_HWRITE;
            h_size1  <= M1_HSIZE;
         end
      end
endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// tb_ahb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
// of the two-master arbiter, with a small word memory acting as the slave.
module tb_ahb_mem_arbiter;
   localparam int AW = 32;
   typedef struct packed {
      logic [31:0] a;
      logic [1:0]  t;
      logic        w;
      logic [2:0]  s;
   } req_t;

   logic HCLK = 1'b0, HRESETn = 1'b0;
   logic M0_HSEL = 1'b0, M1_HSEL = 1'b0;
   logic [AW-1:0] M0_HADDR = '0, M1_HADDR = '0;
   logic [1:0] M0_HTRANS = 2'b00, M1_HTRANS = 2'b00;
   logic M0_HWRITE = 1'b0, M1_HWRITE = 1'b0;
   logic [2:0] M0_HSIZE = 3'b000, M1_HSIZE = 3'b000;
   logic [31:0] M0_HWDATA = '0, M1_HWDATA = '0;
   logic M0_HREADY, M1_HREADY, M0_HREADYOUT, M1_HREADYOUT;
   logic [31:0] M0_HRDATA, M1_HRDATA;
   logic S_HSEL, S_HWRITE, S_HREADY;
   logic [AW-1:0] S_HADDR;
   logic [1:0] S_HTRANS;
   logic [2:0] S_HSIZE;
   logic [31:0] S_HWDATA, S_HRDATA;
   logic S_HREADYOUT = 1'b1;
   int n_vec = 0, n_err = 0;
   logic [40:0] obs, e;

   logic [31:0] mem [0:63];
   logic sl_dv = 1'b0, sl_wr = 1'b0;
   logic [5:0] sl_idx = '0;

   always #5 HCLK = ~HCLK;
   assign M0_HREADY = M0_HREADYOUT;
   assign M1_HREADY = M1_HREADYOUT;
   assign obs = {S_HSEL, S_HTRANS, S_HADDR, S_HWRITE, S_HSIZE, M0_HREADYOUT, M1_HREADYOUT};
   assign S_HRDATA = mem[sl_idx];

   always @(posedge HCLK)
      if (S_HREADYOUT) begin
         if (sl_dv && sl_wr) mem[sl_idx] <= S_HWDATA;
         sl_dv  <= S_HSEL & S_HTRANS[1];
         sl_wr  <= S_HWRITE;
         sl_idx <= S_HADDR[7:2];
      end

   ahb_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .M0_HSEL(M0_HSEL), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
      .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY),
      .M0_HREADYOUT(M0_HREADYOUT), .M0_HRDATA(M0_HRDATA),
      .M1_HSEL(M1_HSEL), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
      .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY),
      .M1_HREADYOUT(M1_HREADYOUT), .M1_HRDATA(M1_HRDATA),
      .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
      .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
      .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA)
   );

   task automatic m0(input logic s, input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] z);
      M0_HSEL = s; M0_HTRANS = t; M0_HADDR = a; M0_HWRITE = w; M0_HSIZE = z;
   endtask

   task automatic m1(input logic s, input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] z);
      M1_HSEL = s; M1_HTRANS = t; M1_HADDR = a; M1_HWRITE = w; M1_HSIZE = z;
   endtask

   task automatic do_reset();
      @(negedge HCLK);
      HRESETn = 1'b0;
      m0(0, 2'b00, 0, 0, 0);
      m1(0, 2'b00, 0, 0, 0);
      S_HREADYOUT = 1'b1;
      @(negedge HCLK);
      HRESETn = 1'b1;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      m0(1, 2'b10, 32'h55, 1, 3'd2);
      m1(1, 2'b10, 32'h66, 1, 3'd2);
      @(negedge HCLK); #1;
      e = {1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL reset_state obs=%h exp=%h", obs, e); end
      do_reset();
   endtask

   task automatic test_m0_alone();
      @(negedge HCLK); m0(1, 2'b10, 32'h10, 1, 3'd2); #1;
      e = {1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL alone_write obs=%h exp=%h", obs, e); end
      @(negedge HCLK); m0(1, 2'b10, 32'h10, 0, 3'd2); M0_HWDATA = 32'hDEADBEEF; #1;
      e = {1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL alone_read obs=%h exp=%h", obs, e); end
      n_vec++; if (S_HWDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL alone_wdata got=%h exp=deadbeef", S_HWDATA); end
      @(negedge HCLK); m0(0, 2'b00, 0, 0, 0); #1;
      e = {1'b0, 2'b00, 32'h10, 1'b0, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL alone_idle obs=%h exp=%h", obs, e); end
      n_vec++; if (M0_HRDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL alone_rdata got=%h exp=deadbeef", M0_HRDATA); end
   endtask

   task automatic test_contention();
      do_reset();
      @(negedge HCLK); m0(1, 2'b10, 32'h4, 1, 3'd0); m1(1, 2'b10, 32'h8, 0, 3'd2); #1;
      e = {1'b1, 2'b10, 32'h4, 1'b1, 3'd0, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL contend_m0_first obs=%h exp=%h", obs, e); end
      @(negedge HCLK); m0(0, 2'b00, 0, 0, 0); m1(0, 2'b00, 0, 0, 0); M0_HWDATA = 32'h11; #1;
      e = {1'b1, 2'b10, 32'h8, 1'b0, 3'd2, 1'b1, 1'b0};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL contend_m1_next obs=%h exp=%h", obs, e); end
      n_vec++; if (S_HWDATA !== 32'h11) begin n_err++; $display("FAIL contend_m0_wdata got=%h exp=00000011", S_HWDATA); end
      @(negedge HCLK); M1_HWDATA = 32'hA5A5A5A5; #1;
      e = {1'b0, 2'b00, 32'h8, 1'b0, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL contend_done obs=%h exp=%h", obs, e); end
      n_vec++; if (M1_HRDATA !== 32'hCAFE0008) begin n_err++; $display("FAIL contend_m1_rdata got=%h exp=cafe0008", M1_HRDATA); end
      n_vec++; if (S_HWDATA !== 32'hA5A5A5A5) begin n_err++; $display("FAIL contend_m1_route got=%h exp=a5a5a5a5", S_HWDATA); end
   endtask

   task automatic test_wait_states();
      do_reset();
      @(negedge HCLK); m0(1, 2'b10, 32'h0, 0, 3'd2); #1;
      e = {1'b1, 2'b10, 32'h0, 1'b0, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL wait_m0_issue obs=%h exp=%h", obs, e); end
      @(negedge HCLK); m0(0, 2'b00, 0, 0, 0); m1(1, 2'b10, 32'hC, 1, 3'd2); S_HREADYOUT = 1'b0; #1;
      e = {1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL wait_first obs=%h exp=%h", obs, e); end
      @(negedge HCLK); m1(0, 2'b00, 0, 0, 0); #1;
      e = {1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 1'b0, 1'b0};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL wait_second obs=%h exp=%h", obs, e); end
      @(negedge HCLK); S_HREADYOUT = 1'b1; #1;
      e = {1'b1, 2'b10, 32'hC, 1'b1, 3'd2, 1'b1, 1'b0};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL wait_m1_issue obs=%h exp=%h", obs, e); end
      @(negedge HCLK); M1_HWDATA = 32'h0000_000C; #1;
      e = {1'b0, 2'b00, 32'hC, 1'b1, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL wait_done obs=%h exp=%h", obs, e); end
   endtask

   task automatic test_seq_switch();
      do_reset();
      @(negedge HCLK); m1(1, 2'b10, 32'h20, 0, 3'd2); #1;
      e = {1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL seq_m1_start obs=%h exp=%h", obs, e); end
      @(negedge HCLK); m1(1, 2'b11, 32'h24, 0, 3'd2); m0(1, 2'b10, 32'h40, 0, 3'd2); #1;
      e = {1'b1, 2'b10, 32'h40, 1'b0, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL seq_m0_cut_in obs=%h exp=%h", obs, e); end
      @(negedge HCLK); m0(0, 2'b00, 0, 0, 0); #1;
      e = {1'b1, 2'b10, 32'h24, 1'b0, 3'd2, 1'b1, 1'b0};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL seq_from_hold obs=%h exp=%h", obs, e); end
      @(negedge HCLK); m0(1, 2'b10, 32'h44, 0, 3'd2); m1(1, 2'b01, 32'h28, 0, 3'd2); #1;
      e = {1'b1, 2'b10, 32'h44, 1'b0, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL seq_busy_m0 obs=%h exp=%h", obs, e); end
      @(negedge HCLK); m0(0, 2'b00, 0, 0, 0); m1(1, 2'b11, 32'h28, 0, 3'd2); #1;
      e = {1'b1, 2'b10, 32'h28, 1'b0, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL seq_after_other obs=%h exp=%h", obs, e); end
      @(negedge HCLK); m1(1, 2'b11, 32'h2C, 0, 3'd2); #1;
      e = {1'b1, 2'b11, 32'h2C, 1'b0, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL seq_kept obs=%h exp=%h", obs, e); end
      @(negedge HCLK); m1(1, 2'b01, 32'h30, 0, 3'd2); #1;
      e = {1'b0, 2'b00, 32'h2C, 1'b0, 3'd2, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL seq_busy_dropped obs=%h exp=%h", obs, e); end
   endtask

   task automatic test_arbitration();
      logic r0, r1;
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge HCLK); m0(1, 2'b10, 32'h100, 0, 3'd2); m1(1, 2'b10, 32'h200, 0, 3'd2); #1;
`ifdef ARB_ROUND_ROBIN_EN
         a = (i % 2 == 0) ? 32'h100 : 32'h200;
         r0 = (i == 0) || (i % 2 == 1);
         r1 = (i % 2 == 0);
`else
         a = 32'h100;
         r0 = 1'b1;
         r1 = (i == 0);
`endif
         e = {1'b1, 2'b10, a, 1'b0, 3'd2, r0, r1};
         n_vec++; if (obs !== e) begin n_err++; $display("FAIL arb_cycle%0d obs=%h exp=%h", i, obs, e); end
      end
      @(negedge HCLK); m0(0, 2'b00, 0, 0, 0); m1(0, 2'b00, 0, 0, 0); #1;
`ifdef ARB_ROUND_ROBIN_EN
      e = {1'b1, 2'b10, 32'h100, 1'b0, 3'd2, 1'b0, 1'b1};
`else
      e = {1'b1, 2'b10, 32'h200, 1'b0, 3'd2, 1'b1, 1'b0};
`endif
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL arb_drain obs=%h exp=%h", obs, e); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge HCLK); S_HREADYOUT = 1'b0; m1(1, 2'b10, 32'h300, 1, 3'd2); #1;
      @(negedge HCLK); S_HREADYOUT = 1'b1; m1(0, 2'b00, 0, 0, 0); m0(1, 2'b10, 32'h400, 1, 3'd1); #1;
      n_vec++; if (M1_HREADYOUT !== 1'b0) begin n_err++; $display("FAIL rstmid_pending got=%b exp=0", M1_HREADYOUT); end
      #2 HRESETn = 1'b0;
      #1;
      e = {1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1};
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL rstmid_async obs=%h exp=%h", obs, e); end
      @(negedge HCLK); HRESETn = 1'b1; m0(0, 2'b00, 0, 0, 0); #1;
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL rstmid_release obs=%h exp=%h", obs, e); end
      @(negedge HCLK); #1;
      n_vec++; if (obs !== e) begin n_err++; $display("FAIL rstmid_hold_gone obs=%h exp=%h", obs, e); end
   endtask

   task automatic test_random(input int n);
      req_t held [2];
      req_t rq [2];
      req_t c;
      bit has [2], fresh [2], want [2], rdy [2], sel [2];
      bit pv, go;
      int po, lastw, w;
      logic [31:0] la, exp_wd;
      logic lw;
      logic [2:0] ls;
      do_reset();
      has[0] = 0; has[1] = 0; pv = 0; po = 0; lastw = 1; la = '0; lw = 1'b0; ls = 3'd0;
      for (int k = 0; k < n; k++) begin
         @(negedge HCLK);
         m0($urandom_range(3) != 0, 2'($urandom_range(3)), 32'($urandom_range(63)) << 2, 1'($urandom_range(1)), 3'($urandom_range(7)));
         m1($urandom_range(3) != 0, 2'($urandom_range(3)), 32'($urandom_range(63)) << 2, 1'($urandom_range(1)), 3'($urandom_range(7)));
         M0_HWDATA = $urandom;
         M1_HWDATA = $urandom;
         S_HREADYOUT = $urandom_range(3) != 0;
         #1;
         rq[0] = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE};
         rq[1] = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE};
         sel[0] = M0_HSEL; sel[1] = M1_HSEL;
         for (int x = 0; x < 2; x++) begin
            rdy[x] = !has[x] && !(pv && po == x && !S_HREADYOUT);
            fresh[x] = sel[x] && rq[x].t[1] && rdy[x];
            want[x] = has[x] || fresh[x];
         end
         go = S_HREADYOUT && (want[0] || want[1]);
`ifdef ARB_ROUND_ROBIN_EN
         w = !want[0] ? 1 : !want[1] ? 0 : (lastw == 0 ? 1 : 0);
`else
         w = want[0] ? 0 : 1;
`endif
         c = has[w] ? held[w] : rq[w];
         if (c.t == 2'b11 && (has[w] || (pv && po != w))) c.t = 2'b10;
         e = go ? {1'b1, c.t, c.a, c.w, c.s, rdy[0], rdy[1]} : {1'b0, 2'b00, la, lw, ls, rdy[0], rdy[1]};
         n_vec++; if (obs !== e) begin n_err++; $display("FAIL rand_ctrl@%0d obs=%h exp=%h", k, obs, e); end
         if (pv) begin
            exp_wd = (po == 1) ? M1_HWDATA : M0_HWDATA;
            n_vec++; if (S_HWDATA !== exp_wd) begin n_err++; $display("FAIL rand_wdata@%0d got=%h exp=%h", k, S_HWDATA, exp_wd); end
         end
         n_vec++; if ({M0_HRDATA, M1_HRDATA, S_HREADY} !== {S_HRDATA, S_HRDATA, S_HREADYOUT}) begin
            n_err++; $display("FAIL rand_return@%0d got=%h/%h/%b exp=%h/%b", k, M0_HRDATA, M1_HRDATA, S_HREADY, S_HRDATA, S_HREADYOUT);
         end
         if (go) begin la = c.a; lw = c.w; ls = c.s; lastw = w; end
         for (int x = 0; x < 2; x++)
            if (go && w == x) has[x] = 0;
            else if (fresh[x]) begin has[x] = 1; held[x] = rq[x]; end
         if (S_HREADYOUT) begin pv = go; po = w; end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h0101_0101;
      mem[2] = 32'hCAFE0008;
      test_reset();
      test_m0_alone();
      test_contention();
      test_wait_states();
      test_seq_switch();
      test_arbitration();
      test_reset_mid();
      test_random(600);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
